// File: rtl/beidou_pkg.sv
// -----------------------------------------------------------------------------
// beidou_pkg
// Shared constants for the BeiDou B1I IF generator:
//   G1_INIT / G2_INIT       - LFSR reload values at every code-period start
//   G1_FB_MASK / G2_FB_MASK - feedback tap masks (bit n set = g[n] feeds back)
//   CODE_LEN_DEF            - default chips per code period
//   state_t                 - generator control state
//   map_tap / lfsr_fb       - tap-index clamp and feedback XOR helpers
// -----------------------------------------------------------------------------
package beidou_pkg;

    localparam int          CODE_LEN_DEF = 2046;
    localparam logic [10:0] G1_INIT      = 11'b11010110101;
    localparam logic [10:0] G2_INIT      = 11'b00001000101;
    localparam logic [10:0] G1_FB_MASK   = 11'b11111000001;
    localparam logic [10:0] G2_FB_MASK   = 11'b11110011111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Tap indices above 10 select the last G2 stage.
    function automatic logic [3:0] map_tap(input logic [3:0] t);
        return (t > 4'd10) ? 4'd10 : t;
    endfunction

    function automatic logic lfsr_fb(input logic [10:0] r, input logic [10:0] m);
        return ^(r & m);
    endfunction

endpackage

// File: rtl/beidou_ch_mod.sv
// -----------------------------------------------------------------------------
// beidou_ch_mod
// One IF channel: navigation-bit holding register, active bit, G2 phase
// selection and the symbol x carrier product.
//   clk, rst_n        clock, synchronous active-low reset
//   adv_i             generator advancing this cycle (low = idle / leaving RUN)
//   bit_bnd_i         data-bit boundary at the end of this cycle
//   g1_msb_i, g2_i    shared LFSR state
//   tap_a_i, tap_b_i  latched G2 tap indices
//   car_ph_i          latched carrier quadrant offset
//   phase_i           shared carrier phase
//   data_in_i/_valid_i, data_ready_o   navigation bit handshake
//   underrun_o        sticky: boundary seen with empty holding register
//   sample_o          signed sample in {-1, 0, +1}
// -----------------------------------------------------------------------------
module beidou_ch_mod
    import beidou_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    input  logic              bit_bnd_i,
    input  logic              g1_msb_i,
    input  logic [10:0]       g2_i,
    input  logic [3:0]        tap_a_i,
    input  logic [3:0]        tap_b_i,
    input  logic [1:0]        car_ph_i,
    input  logic [1:0]        phase_i,
    input  logic              data_in_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              underrun_o,
    output logic signed [1:0] sample_o
);

    logic       hold_full_q, hold_full_d;
    logic       hold_bit_q, hold_bit_d;
    logic       active_q, active_d;
    logic       underrun_q, underrun_d;
    logic [3:0] ta, tb;
    logic [1:0] quad;
    logic       code, sym;

    assign data_ready_o = ~hold_full_q;
    assign underrun_o   = underrun_q;

    always_comb begin
        hold_full_d = hold_full_q;
        hold_bit_d  = hold_bit_q;
        active_d    = active_q;
        underrun_d  = underrun_q;
        // A transfer can only happen while empty, so it never collides with
        // the boundary consuming a full register.
        if (data_valid_i && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_bit_d  = data_in_i;
        end
        if (!adv_i) begin
            active_d   = 1'b0;
            underrun_d = 1'b0;
        end else if (bit_bnd_i) begin
            if (hold_full_q) begin
                active_d    = hold_bit_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_bit_q  <= 1'b0;
            active_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_bit_q  <= hold_bit_d;
            active_q    <= active_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        ta   = map_tap(tap_a_i);
        tb   = map_tap(tap_b_i);
        code = g1_msb_i ^ g2_i[ta] ^ ((ta == tb) ? 1'b0 : g2_i[tb]);
        sym  = active_q ^ code;
        quad = phase_i + car_ph_i;
        case (quad)
            2'd0:    sample_o = sym ? 2'sb11 : 2'sb01;
            2'd2:    sample_o = sym ? 2'sb01 : 2'sb11;
            default: sample_o = 2'sb00;
        endcase
    end

endmodule

// File: rtl/beidou_if_gen.sv
// -----------------------------------------------------------------------------
// beidou_if_gen
// Multi-channel BeiDou B1I-style IF sample generator: shared chip timing,
// G1/G2 LFSRs and carrier phase; per-channel modulation in beidou_ch_mod.
//   clk, rst_n            clock, synchronous active-low reset
//   run                   high = generate, low = idle
//   g2_tap_a/_b, car_ph   per-channel config, latched on IDLE->RUN
//   data_in/_valid/_ready per-channel navigation bit handshake
//   if_out                registered signed sum of channel samples
//   epoch, bit_strobe     code-period / data-bit start pulses, aligned with if_out
//   underrun              sticky per-channel empty-at-boundary flags
// -----------------------------------------------------------------------------
module beidou_if_gen
    import beidou_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CHIP_DIV       = 3052,
    parameter int CODE_LEN       = CODE_LEN_DEF,
    parameter int EPOCHS_PER_BIT = 2,
    parameter int OUT_W          = $clog2(NUM_CH + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [4*NUM_CH-1:0]     g2_tap_a,
    input  logic [4*NUM_CH-1:0]     g2_tap_b,
    input  logic [2*NUM_CH-1:0]     car_ph,
    input  logic [NUM_CH-1:0]       data_in,
    input  logic [NUM_CH-1:0]       data_valid,
    output logic [NUM_CH-1:0]       data_ready,
    output logic signed [OUT_W-1:0] if_out,
    output logic                    epoch,
    output logic                    bit_strobe,
    output logic [NUM_CH-1:0]       underrun
);

    localparam int CW = $clog2(CHIP_DIV);
    localparam int IW = $clog2(CODE_LEN);
    localparam int EW = $clog2(EPOCHS_PER_BIT + 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           chip_cnt_q, chip_cnt_d;
    logic [IW-1:0]           chip_idx_q, chip_idx_d;
    logic [EW-1:0]           ep_cnt_q, ep_cnt_d;
    logic [10:0]             g1_q, g1_d, g2_q, g2_d;
    logic [1:0]              phase_q, phase_d;
    logic [4*NUM_CH-1:0]     tap_a_q, tap_a_d, tap_b_q, tap_b_d;
    logic [2*NUM_CH-1:0]     car_q, car_d;
    logic                    ep_pend_q, bit_pend_q;
    logic                    epoch_q, bit_q;
    logic signed [OUT_W-1:0] if_q, if_d, sum;
    logic signed [1:0]       smp [NUM_CH];
    logic                    adv, chip_tick, code_end, wrap, bit_bnd;

    assign adv       = (state_q == ST_RUN) && run;
    assign chip_tick = (chip_cnt_q == CW'(CHIP_DIV - 1));
    assign code_end  = (chip_idx_q == IW'(CODE_LEN - 1));
    assign wrap      = adv && chip_tick && code_end;
    assign bit_bnd   = wrap && (ep_cnt_q == EW'(EPOCHS_PER_BIT - 1));

    always_comb begin
        state_d    = state_q;
        tap_a_d    = tap_a_q;
        tap_b_d    = tap_b_q;
        car_d      = car_q;
        chip_cnt_d = '0;
        chip_idx_d = '0;
        ep_cnt_d   = '0;
        phase_d    = '0;
        g1_d       = G1_INIT;
        g2_d       = G2_INIT;
        case (state_q)
            ST_IDLE: if (run) begin
                state_d = ST_RUN;
                tap_a_d = g2_tap_a;
                tap_b_d = g2_tap_b;
                car_d   = car_ph;
            end
            ST_RUN:  if (!run) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Timing state only advances while RUN persists; any other cycle
        // (idle, or the last RUN cycle) loads the initial values.
        if (adv) begin
            phase_d    = phase_q + 2'd1;
            chip_cnt_d = chip_cnt_q + CW'(1);
            chip_idx_d = chip_idx_q;
            ep_cnt_d   = ep_cnt_q;
            g1_d       = g1_q;
            g2_d       = g2_q;
            if (chip_tick) begin
                chip_cnt_d = '0;
                if (code_end) begin
                    chip_idx_d = '0;
                    g1_d       = G1_INIT;
                    g2_d       = G2_INIT;
                    ep_cnt_d   = bit_bnd ? '0 : ep_cnt_q + EW'(1);
                end else begin
                    chip_idx_d = chip_idx_q + IW'(1);
                    g1_d       = {g1_q[9:0], lfsr_fb(g1_q, G1_FB_MASK)};
                    g2_d       = {g2_q[9:0], lfsr_fb(g2_q, G2_FB_MASK)};
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sum = sum + OUT_W'(smp[i]);
        end
        if_d = (state_q == ST_RUN) ? sum : '0;
    end

    // Boundary pulses are delayed twice: once to reach the chip-0 cycle,
    // once more to line up with that cycle's registered if_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            chip_cnt_q <= '0;
            chip_idx_q <= '0;
            ep_cnt_q   <= '0;
            phase_q    <= '0;
            g1_q       <= G1_INIT;
            g2_q       <= G2_INIT;
            tap_a_q    <= '0;
            tap_b_q    <= '0;
            car_q      <= '0;
            ep_pend_q  <= 1'b0;
            bit_pend_q <= 1'b0;
            epoch_q    <= 1'b0;
            bit_q      <= 1'b0;
            if_q       <= '0;
        end else begin
            state_q    <= state_d;
            chip_cnt_q <= chip_cnt_d;
            chip_idx_q <= chip_idx_d;
            ep_cnt_q   <= ep_cnt_d;
            phase_q    <= phase_d;
            g1_q       <= g1_d;
            g2_q       <= g2_d;
            tap_a_q    <= tap_a_d;
            tap_b_q    <= tap_b_d;
            car_q      <= car_d;
            ep_pend_q  <= wrap;
            bit_pend_q <= bit_bnd;
            epoch_q    <= ep_pend_q;
            bit_q      <= bit_pend_q;
            if_q       <= if_d;
        end
    end

    assign if_out     = if_q;
    assign epoch      = epoch_q;
    assign bit_strobe = bit_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        beidou_ch_mod u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .adv_i        (adv),
            .bit_bnd_i    (bit_bnd),
            .g1_msb_i     (g1_q[10]),
            .g2_i         (g2_q),
            .tap_a_i      (tap_a_q[4*c +: 4]),
            .tap_b_i      (tap_b_q[4*c +: 4]),
            .car_ph_i     (car_q[2*c +: 2]),
            .phase_i      (phase_q),
            .data_in_i    (data_in[c]),
            .data_valid_i (data_valid[c]),
            .data_ready_o (data_ready[c]),
            .underrun_o   (underrun[c]),
            .sample_o     (smp[c])
        );
    end

endmodule

// File: tb/tb_beidou_if_gen.sv
// -----------------------------------------------------------------------------
// tb_beidou_if_gen
// Random-configuration bench for beidou_if_gen (4 channels, 4 clocks/chip).
// The driver pushes the expected registered response of every cycle into a
// queue; the monitor pops and compares one cycle later.
// -----------------------------------------------------------------------------
module tb_beidou_if_gen;

    localparam int NCH    = 4;
    localparam int CDIV   = 4;
    localparam int CLEN   = 2046;
    localparam int EPB    = 2;
    localparam int OW     = 4;
    localparam int PER    = CDIV * CLEN;
    localparam int BITLEN = PER * EPB;

    logic                 clk = 1'b0;
    logic                 rst_n, run;
    logic [4*NCH-1:0]     g2_tap_a, g2_tap_b;
    logic [2*NCH-1:0]     car_ph;
    logic [NCH-1:0]       data_in, data_valid, data_ready, underrun;
    logic signed [OW-1:0] if_out;
    logic                 epoch, bit_strobe;

    beidou_if_gen #(.NUM_CH(NCH), .CHIP_DIV(CDIV), .CODE_LEN(CLEN), .EPOCHS_PER_BIT(EPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .g2_tap_a   (g2_tap_a),
        .g2_tap_b   (g2_tap_b),
        .car_ph     (car_ph),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .if_out     (if_out),
        .epoch      (epoch),
        .bit_strobe (bit_strobe),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        int           ifo;
        bit           ep;
        bit           bs;
        logic [NCH-1:0] rdy;
        logic [NCH-1:0] ur;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Bit-true code tables: LFSR contents at each chip index of a period.
    logic [10:0] g1arr [CLEN];
    logic [10:0] g2arr [CLEN];

    // Reference model state.
    bit       m_run;
    int       mn;
    int       mta [NCH];
    int       mtb [NCH];
    int       mcar[NCH];
    bit       hfull[NCH], hbit[NCH], act[NCH], ur[NCH];

    task automatic build_tables();
        logic [10:0] g1, g2;
        g1 = 11'b11010110101;
        g2 = 11'b00001000101;
        for (int k = 0; k < CLEN; k++) begin
            g1arr[k] = g1;
            g2arr[k] = g2;
            g1 = {g1[9:0], g1[10]^g1[9]^g1[8]^g1[7]^g1[6]^g1[0]};
            g2 = {g2[9:0], g2[10]^g2[9]^g2[8]^g2[7]^g2[4]^g2[3]^g2[2]^g2[1]^g2[0]};
        end
    endtask

    function automatic int chan_sample(input int ch, input int n);
        int k, ta, tb, qd;
        bit code, sym;
        k    = (n / CDIV) % CLEN;
        ta   = (mta[ch] > 10) ? 10 : mta[ch];
        tb   = (mtb[ch] > 10) ? 10 : mtb[ch];
        code = g1arr[k][10] ^ g2arr[k][ta];
        if (ta != tb) code = code ^ g2arr[k][tb];
        sym  = act[ch] ^ code;
        qd   = (n + mcar[ch]) % 4;
        if (qd == 0) return sym ? -1 : 1;
        if (qd == 2) return sym ? 1 : -1;
        return 0;
    endfunction

    // Predict this cycle's registered response, update the model, advance.
    task automatic tick();
        exp_t e;
        int   s;
        bit   adv, bnd, was_full;
        e.due = cyc + 1;
        if (!rst_n) begin
            m_run = 0;
            mn    = 0;
            for (int c = 0; c < NCH; c++) begin
                hfull[c] = 0; hbit[c] = 0; act[c] = 0; ur[c] = 0;
            end
            e.ifo = 0; e.ep = 0; e.bs = 0;
        end else begin
            s = 0;
            if (m_run) for (int c = 0; c < NCH; c++) s += chan_sample(c, mn);
            e.ifo = s;
            e.ep  = m_run && (mn > 0) && (mn % PER == 0);
            e.bs  = m_run && (mn > 0) && (mn % BITLEN == 0);
            adv   = m_run && run;
            bnd   = adv && ((mn + 1) % BITLEN == 0);
            for (int c = 0; c < NCH; c++) begin
                was_full = hfull[c];
                if (data_valid[c] && !hfull[c]) begin
                    hfull[c] = 1; hbit[c] = data_in[c];
                end
                if (!adv) begin
                    act[c] = 0; ur[c] = 0;
                end else if (bnd) begin
                    if (was_full) begin act[c] = hbit[c]; hfull[c] = 0; end
                    else ur[c] = 1;
                end
            end
            if (adv) mn++; else mn = 0;
            if (!m_run && run) begin
                m_run = 1;
                for (int c = 0; c < NCH; c++) begin
                    mta[c]  = int'(g2_tap_a[4*c +: 4]);
                    mtb[c]  = int'(g2_tap_b[4*c +: 4]);
                    mcar[c] = int'(car_ph[2*c +: 2]);
                end
            end else if (m_run && !run) begin
                m_run = 0;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            e.rdy[c] = !hfull[c];
            e.ur[c]  = ur[c];
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cfg();
        g2_tap_a = 16'($urandom);
        g2_tap_b = 16'($urandom);
        car_ph   = 8'($urandom);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            checks++;
            if (if_out !== OW'(e.ifo) || epoch !== e.ep || bit_strobe !== e.bs ||
                data_ready !== e.rdy || underrun !== e.ur) begin
                errors++;
                $display("FAIL out cyc=%0d actual if_out=%0d epoch=%b bit_strobe=%b data_ready=%b underrun=%b required if_out=%0d epoch=%b bit_strobe=%b data_ready=%b underrun=%b",
                         cyc, if_out, epoch, bit_strobe, data_ready, underrun,
                         e.ifo, e.ep, e.bs, e.rdy, e.ur);
            end
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b0;
        data_in = '0; data_valid = '0;
        rand_cfg();
        build_tables();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // First bit period with no data; ch1 taps equal, ch2 tap above 10.
        rand_cfg();
        g2_tap_b[7:4]  = g2_tap_a[7:4];
        g2_tap_a[11:8] = 4'($urandom_range(11, 15));
        run = 1'b1;
        for (int i = 0; i < BITLEN + 20; i++) begin
            data_valid = '0;
            // ch3 transfers exactly on the boundary while empty.
            if (m_run && ((mn + 1) % BITLEN == 0)) begin
                data_valid[3] = 1'b1;
                data_in[3]    = 1'b1;
            end
            tick();
        end

        // Load new bits (ch0 inverts), then change config mid-run.
        data_in    = 4'($urandom);
        data_in[0] = 1'b1;
        data_valid = 4'b0111;
        tick();
        data_valid = '0;
        for (int i = 0; i < BITLEN + 40; i++) begin
            if (i == 8000) rand_cfg();
            if (i > 8000) begin
                for (int c = 0; c < NCH; c++)
                    data_valid[c] = ($urandom_range(0, 2999) == 0);
                data_in = 4'($urandom);
            end else begin
                data_valid = '0;
            end
            tick();
        end

        // Reset pulse mid-code with a handshake in progress.
        data_valid = '0;
        repeat ($urandom_range(500, 1500)) tick();
        data_valid = 4'b1111;
        data_in    = 4'($urandom);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        data_valid = '0;
        repeat (3000) tick();

        // Identical taps, opposing carriers: output cancels to zero.
        run = 1'b0;
        repeat (2) tick();
        g2_tap_a = {4{4'd3}};
        g2_tap_b = {4{4'd7}};
        car_ph   = {2'd2, 2'd0, 2'd2, 2'd0};
        run = 1'b1;
        repeat (PER + 30) tick();

        // Same taps, aligned carriers: output in {+4, 0, -4}.
        run = 1'b0;
        tick();
        car_ph = '0;
        run = 1'b1;
        repeat (3000) tick();
        run = 1'b0;
        repeat (3) tick();

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual pending=%0d required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beidou_if_gen.md
BEIDOU_IF_GEN -- requirements
Module: beidou_if_gen

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, number of channels (1..8); CHIP_DIV, default 3052, clocks per chip (>=2); CODE_LEN, default 2046, chips per code period; EPOCHS_PER_BIT, default 2, code periods per data bit; OUT_W, default $clog2(NUM_CH+1)+1, output width.
REQ-002 clk  in  1  clock; all logic rising-edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 run  in  1  level; high = generate, low = idle.
REQ-005 g2_tap_a, g2_tap_b  in  4*NUM_CH  per-channel G2 phase-selector tap indices (0..10).
REQ-006 car_ph  in  2*NUM_CH  per-channel carrier quadrant offset.
REQ-007 data_in, data_valid  in  NUM_CH each  per-channel navigation bit and valid.
REQ-008 data_ready  out  NUM_CH  per-channel holding register empty.
REQ-009 if_out  out  OUT_W  signed sum of enabled channel IF samples.
REQ-010 epoch, bit_strobe  out  1 each  one-cycle code-period / data-bit boundary pulses.
REQ-011 underrun  out  NUM_CH  sticky per-channel "boundary with empty holding register".

Function
REQ-012 FSM SHALL have IDLE and RUN; IDLE->RUN when run=1, RUN->IDLE in the cycle after run=0; all counters, LFSRs, carrier phase and active bits reinitialise on entry to IDLE.
REQ-013 On IDLE->RUN, g2_tap_a/b and car_ph SHALL be latched; changes while in RUN are ignored.
REQ-014 Chip counter SHALL count 0..CHIP_DIV-1; chip_tick = (count == CHIP_DIV-1).
REQ-015 On chip_tick, G1 SHALL shift left with new LSB = g1[10]^g1[9]^g1[8]^g1[7]^g1[6]^g1[0]; G2 SHALL shift left with new LSB = g2[10]^g2[9]^g2[8]^g2[7]^g2[4]^g2[3]^g2[2]^g2[1]^g2[0].
REQ-016 Chip index SHALL count 0..CODE_LEN-1; on chip_tick at index CODE_LEN-1, G1/G2 SHALL reload init values rather than shift, index returns to 0, epoch counter increments mod EPOCHS_PER_BIT.
REQ-017 Channel code SHALL be g1[10] ^ g2[tap_a] ^ g2[tap_b]; tap_a==tap_b uses single g2[tap_a]; tap values 11..15 SHALL map to 10.
REQ-018 Channel symbol b = active_bit ^ code; b=0 -> +1, b=1 -> -1.
REQ-019 Carrier phase counter SHALL increment every RUN cycle from 0; channel quadrant q = phase + car_ph (mod 4); q=0 -> x1, q=2 -> x-1, q=1,3 -> 0.
REQ-020 if_out SHALL be registered: sum of all channel samples from cycle t appears in t+1; range -NUM_CH..+NUM_CH, never saturates.
REQ-021 epoch SHALL pulse aligned with if_out of chip index 0 of each new period; bit_strobe aligned with the epoch that starts a new data bit.
REQ-022 Transfer when data_valid & data_ready; data_ready = holding register empty.
REQ-023 At bit boundary: full holding register -> active bit, register empty next cycle; empty -> active bit repeats, underrun bit sets.
REQ-024 Transfer coinciding with a boundary while empty SHALL fill the holding register and SHALL still record underrun.
REQ-025 underrun SHALL clear only on reset or IDLE entry.

Reset
REQ-026 On rst_n=0: state IDLE, if_out=0, epoch=0, bit_strobe=0, data_ready=all 1, underrun=0, active bits 0, G1/G2 init, counters 0.
REQ-027 Reset mid-RUN SHALL take effect next edge regardless of handshake in progress; pending held bits are discarded.

Structure
REQ-028 Package beidou_pkg SHALL hold G1_INIT=11'b11010110101, G2_INIT=11'b00001000101, feedback tap masks, CODE_LEN default, and the state enum.
REQ-029 Sub-module beidou_ch_mod (per-channel holding register, active bit, tap select, symbol/carrier product), instantiated NUM_CH times; shared LFSRs/timing in top.

Verification
REQ-030 NUM_CH=1, CHIP_DIV=4, taps 0/2, car_ph 0, bit 0 -> if_out +/-1 on even cycles, 0 on odd; chip sequence matches bit-true model over 2046 chips.
REQ-031 CHIP_DIV=4, run held -> epoch every 8184 cycles; bit_strobe every 16368 cycles.
REQ-032 No data supplied -> underrun=1 at first bit_strobe, active bit stays 0; then push 1 -> output polarity inverts at next bit_strobe.
REQ-033 NUM_CH=4, identical taps, car_ph 0, all bits 0 -> if_out in {+4,0,-4}; car_ph {0,2,0,2} -> if_out constant 0.
REQ-034 rst_n=0 for one cycle mid-code -> next cycle if_out=0, data_ready=all 1; restart reproduces REQ-030 sequence from chip 0.
REQ-035 Change taps during RUN -> no output change; toggle run low/high -> new taps take effect from chip 0.
